dma_io_responder: RTL and testbench

- Peripheral-side endpoint of the 8237-style DMA single-transfer protocol; the device the controller serves.
- Raises DREQ when it can source or sink a byte, then answers DACK plus IOR_n/IOW_n strobes on the shared DB bus.
- Buffers bytes in two show-ahead FIFOs: TX for device-to-memory traffic, RX for memory-to-device traffic.
- Sits on the system bus beside the controller datapath and serves as the reusable device model for integration benches.

---
 rtl/dma_pkg.sv | 15 +
 rtl/byte_fifo.sv | 55 +++++
 rtl/dma_io_responder.sv | 138 +++++++++++++
 tb/tb_dma_io_responder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and constants for the DMA I/O responder
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACK,
        XFER,
        HOLD
    } responder_state_t;

    localparam logic DIR_SOURCE = 1'b0;
    localparam logic DIR_SINK   = 1'b1;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous show-ahead FIFO; head reads 0 while empty
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    // Push on full and pop on empty are silently discarded.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/dma_io_responder.sv
// rtl/dma_io_responder.sv - peripheral endpoint for 8237-style single DMA transfers
module dma_io_responder
    import dma_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic          Clock,
    input  logic          Reset,
    output logic          DREQ,
    input  logic          DACK,
    input  logic          IOR_n,
    input  logic          IOW_n,
    input  logic          EOP_n,
    inout  wire  [DW-1:0] DB,
    input  logic          enable,
    input  logic          dir,
    input  logic          tc_clear,
    input  logic          tx_push,
    input  logic [DW-1:0] tx_data,
    output logic          tx_full,
    input  logic          rx_pop,
    output logic [DW-1:0] rx_data,
    output logic          rx_empty,
    output logic          tc_flag,
    output logic          err_flag,
    output logic [7:0]    xfer_count
);

    responder_state_t state, state_nx;
    logic          xdir;
    logic          ior_q;
    logic          iow_q;
    logic [DW-1:0] db_cap;
    logic          tx_empty;
    logic          rx_full;
    logic [DW-1:0] tx_head;
    logic          eff_dir;
    logic          ready;
    logic          match_n;
    logic          match_end;
    logic          wrong_low;
    logic          done;
    logic          in_cycle;
    logic          db_drive;

    // Direction is latched on leaving IDLE so a mid-transfer change waits for the next one.
    assign eff_dir   = (state == IDLE) ? dir : xdir;
    assign ready     = (eff_dir == DIR_SOURCE) ? !tx_empty : !rx_full;
    assign match_n   = (xdir == DIR_SINK) ? IOW_n : IOR_n;
    assign match_end = (xdir == DIR_SINK) ? (!iow_q && IOW_n) : (!ior_q && IOR_n);
    assign wrong_low = DACK && ((eff_dir == DIR_SINK) ? !IOR_n : !IOW_n);
    assign in_cycle  = (state == ACK) || (state == XFER) || (state == HOLD);
    assign db_drive  = (xdir == DIR_SOURCE) && DACK && !IOR_n &&
                       ((state == ACK) || (state == XFER));
    assign DB        = db_drive ? tx_head : {DW{1'bz}};

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        case (state)
            IDLE: if (enable && ready && !tc_flag) state_nx = REQ;
            REQ: begin
                if (DACK)                  state_nx = ACK;
                else if (!enable || !ready) state_nx = IDLE;
            end
            ACK: begin
                if (!match_n)  state_nx = XFER;
                else if (!DACK) state_nx = IDLE;
            end
            XFER: begin
                if (match_end) begin
                    done     = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: if (!DACK) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state      <= IDLE;
            DREQ       <= 1'b0;
            xdir       <= DIR_SOURCE;
            ior_q      <= 1'b1;
            iow_q      <= 1'b1;
            db_cap     <= '0;
            tc_flag    <= 1'b0;
            err_flag   <= 1'b0;
            xfer_count <= '0;
        end else begin
            state <= state_nx;
            DREQ  <= (state_nx == REQ);
            ior_q <= IOR_n;
            iow_q <= IOW_n;
            if (state == IDLE) begin
                xdir <= dir;
            end
            if (((state == ACK) || (state == XFER)) && (xdir == DIR_SINK) && !IOW_n) begin
                db_cap <= DB;
            end
            if (in_cycle && !EOP_n) begin
                tc_flag <= 1'b1;
            end else if (tc_clear) begin
                tc_flag <= 1'b0;
            end
            if (wrong_low) begin
                err_flag <= 1'b1;
            end
            xfer_count <= xfer_count + {7'b0, done};
        end
    end

    byte_fifo #(.DEPTH(DEPTH), .DW(DW)) u_tx_fifo (
        .clk    (Clock),
        .resetn (Reset),
        .push   (tx_push),
        .pop    (done && (xdir == DIR_SOURCE)),
        .din    (tx_data),
        .full   (tx_full),
        .empty  (tx_empty),
        .head   (tx_head)
    );

    byte_fifo #(.DEPTH(DEPTH), .DW(DW)) u_rx_fifo (
        .clk    (Clock),
        .resetn (Reset),
        .push   (done && (xdir == DIR_SINK)),
        .pop    (rx_pop),
        .din    (db_cap),
        .full   (rx_full),
        .empty  (rx_empty),
        .head   (rx_data)
    );

endmodule

// File: tb/tb_dma_io_responder.sv
// tb/tb_dma_io_responder.sv - randomized self-checking bench with queue-based device model
module tb_dma_io_responder;

    localparam int DEPTH = 8;
    localparam int DW    = 8;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    logic DREQ;
    logic DACK = 1'b0, IOR_n = 1'b1, IOW_n = 1'b1, EOP_n = 1'b1;
    wire  [DW-1:0] DB;
    logic db_en = 1'b0;
    logic [DW-1:0] db_drv = '0;
    logic enable = 1'b0, dir = 1'b0, tc_clear = 1'b0, tx_push = 1'b0, rx_pop = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic tx_full, rx_empty, tc_flag, err_flag;
    logic [DW-1:0] rx_data;
    logic [7:0] xfer_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    int m_count;
    bit m_tc;

    assign DB = db_en ? db_drv : {DW{1'bz}};

    dma_io_responder #(.DEPTH(DEPTH), .DW(DW)) dut (
        .Clock(Clock), .Reset(Reset), .DREQ(DREQ), .DACK(DACK), .IOR_n(IOR_n),
        .IOW_n(IOW_n), .EOP_n(EOP_n), .DB(DB), .enable(enable), .dir(dir),
        .tc_clear(tc_clear), .tx_push(tx_push), .tx_data(tx_data), .tx_full(tx_full),
        .rx_pop(rx_pop), .rx_data(rx_data), .rx_empty(rx_empty), .tc_flag(tc_flag),
        .err_flag(err_flag), .xfer_count(xfer_count)
    );

    always #5 Clock = ~Clock;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0; DACK = 1'b0; IOR_n = 1'b1; IOW_n = 1'b1; EOP_n = 1'b1;
        db_en = 1'b0; enable = 1'b0; tc_clear = 1'b0; tx_push = 1'b0; rx_pop = 1'b0;
        tick(); tick();
        Reset = 1'b1;
        tx_q.delete(); rx_q.delete(); m_count = 0; m_tc = 0;
    endtask

    task automatic set_mode(input logic d, input logic en);
        enable = 1'b0;
        tick(); tick();
        dir = d; enable = en;
    endtask

    task automatic push_tx(input logic [7:0] d);
        tx_data = d; tx_push = 1'b1;
        tick();
        tx_push = 1'b0;
        if (tx_q.size() < DEPTH) tx_q.push_back(d);
    endtask

    task automatic pop_rx(input string name);
        logic [7:0] exp;
        exp = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        checks++;
        if (rx_data !== exp) begin errors++; $display("FAIL %s: rx_data=%h expected %h", name, rx_data, exp); end
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
        if (rx_q.size() > 0) void'(rx_q.pop_front());
    endtask

    task automatic wait_dreq(input string name, output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (DREQ === 1'b1) begin ok = 1; break; end
            tick();
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL %s: DREQ=%b expected 1 within 20 cycles", name, DREQ); end
    endtask

    task automatic quiet_dreq(input string name, input int n);
        bit seen = 0;
        for (int i = 0; i < n; i++) begin
            if (DREQ !== 1'b0) seen = 1;
            tick();
        end
        checks++;
        if (seen) begin errors++; $display("FAIL %s: DREQ=1 expected 0 for %0d cycles", name, n); end
    endtask

    // eop: 0 none, 1 EOP_n low during strobe, 2 EOP_n low together with tc_clear
    task automatic dma_xfer(input string name, input int eop, input bit push_end,
                            input logic [7:0] pd, input logic [7:0] sd);
        bit ok;
        logic [7:0] exp;
        wait_dreq(name, ok);
        if (!ok) return;
        DACK = 1'b1;
        tick();
        checks++;
        if (DREQ !== 1'b0) begin errors++; $display("FAIL %s_ack: DREQ=%b expected 0", name, DREQ); end
        if (dir == 1'b0) IOR_n = 1'b0;
        else begin IOW_n = 1'b0; db_drv = sd; db_en = 1'b1; end
        if (eop != 0) EOP_n = 1'b0;
        if (eop == 2) tc_clear = 1'b1;
        tick(); tick();
        if (dir == 1'b0) begin
            exp = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
            checks++;
            if (DB !== exp) begin errors++; $display("FAIL %s_db: DB=%h expected %h", name, DB, exp); end
        end
        IOR_n = 1'b1; IOW_n = 1'b1; EOP_n = 1'b1; tc_clear = 1'b0; db_en = 1'b0;
        if (push_end) begin tx_data = pd; tx_push = 1'b1; end
        tick();
        tx_push = 1'b0;
        if (push_end && tx_q.size() < DEPTH) tx_q.push_back(pd);
        if (dir == 1'b0) void'(tx_q.pop_front());
        else rx_q.push_back(sd);
        m_count = (m_count + 1) % 256;
        if (eop != 0) m_tc = 1;
        DACK = 1'b0;
        tick();
        checks++;
        if (xfer_count !== 8'(m_count)) begin errors++; $display("FAIL %s_count: xfer_count=%0d expected %0d", name, xfer_count, m_count); end
        checks++;
        if (tc_flag !== m_tc) begin errors++; $display("FAIL %s_tc: tc_flag=%b expected %b", name, tc_flag, m_tc); end
        checks++;
        if (tx_full !== (tx_q.size() == DEPTH)) begin errors++; $display("FAIL %s_txfull: tx_full=%b expected %b", name, tx_full, tx_q.size() == DEPTH); end
        checks++;
        if (rx_empty !== (rx_q.size() == 0)) begin errors++; $display("FAIL %s_rxempty: rx_empty=%b expected %b", name, rx_empty, rx_q.size() == 0); end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({DREQ, tc_flag, err_flag, tx_full, rx_empty} !== 5'b00001)
            begin errors++; $display("FAIL %s_flags: DREQ,tc,err,tx_full,rx_empty=%b expected 00001", name, {DREQ, tc_flag, err_flag, tx_full, rx_empty}); end
        checks++;
        if (xfer_count !== 8'd0) begin errors++; $display("FAIL %s_count: xfer_count=%0d expected 0", name, xfer_count); end
        checks++;
        if (rx_data !== 8'd0) begin errors++; $display("FAIL %s_rxdata: rx_data=%h expected 00", name, rx_data); end
        db_drv = 8'h5A; db_en = 1'b1;
        #1;
        checks++;
        if (DB !== 8'h5A) begin errors++; $display("FAIL %s_db: DB=%h expected bus released (5a from bench)", name, DB); end
        db_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_outputs("reset");
    endtask

    task automatic test_source();
        set_mode(1'b0, 1'b1);
        push_tx(8'hA5);
        push_tx(8'h3C);
        dma_xfer("src1", 0, 0, 8'h00, 8'h00);
        dma_xfer("src2", 0, 0, 8'h00, 8'h00);
        quiet_dreq("src_empty", 10);
    endtask

    task automatic test_sink();
        set_mode(1'b1, 1'b1);
        for (int i = 0; i < DEPTH; i++) dma_xfer("sink", 0, 0, 8'h00, 8'(8'h10 + i));
        quiet_dreq("sink_full", 10);
        pop_rx("sink_pop_first");
        dma_xfer("sink9", 0, 0, 8'h00, 8'h18);
        for (int i = 0; i < DEPTH; i++) pop_rx("sink_pop");
        checks++;
        if (rx_empty !== 1'b1) begin errors++; $display("FAIL sink_drained: rx_empty=%b expected 1", rx_empty); end
    endtask

    task automatic test_tc();
        bit ok;
        do_reset();
        set_mode(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) push_tx(8'($urandom));
        dma_xfer("tc1", 0, 0, 8'h00, 8'h00);
        dma_xfer("tc2", 0, 0, 8'h00, 8'h00);
        dma_xfer("tc3", 1, 0, 8'h00, 8'h00);
        quiet_dreq("tc_block", 10);
        tc_clear = 1'b1; tick(); tc_clear = 1'b0; m_tc = 0;
        checks++;
        if (tc_flag !== 1'b0) begin errors++; $display("FAIL tc_clear: tc_flag=%b expected 0", tc_flag); end
        wait_dreq("tc_rerequest", ok);
        dma_xfer("tc_setwins", 2, 0, 8'h00, 8'h00);
        tc_clear = 1'b1; tick(); tc_clear = 1'b0; m_tc = 0;
    endtask

    task automatic test_abort();
        bit ok;
        do_reset();
        set_mode(1'b0, 1'b1);
        push_tx(8'($urandom));
        wait_dreq("abort_req", ok);
        DACK = 1'b1; tick();
        DACK = 1'b0; tick();
        checks++;
        if (xfer_count !== 8'(m_count)) begin errors++; $display("FAIL abort_count: xfer_count=%0d expected %0d", xfer_count, m_count); end
        dma_xfer("abort_retry", 0, 0, 8'h00, 8'h00);
        push_tx(8'($urandom));
        wait_dreq("rst_req", ok);
        DACK = 1'b1; tick();
        IOR_n = 1'b0; tick(); tick();
        Reset = 1'b0; tick();
        tx_q.delete(); rx_q.delete(); m_count = 0; m_tc = 0;
        check_reset_outputs("reset_xfer");
        DACK = 1'b0; IOR_n = 1'b1; Reset = 1'b1;
        quiet_dreq("reset_xfer_idle", 5);
    endtask

    task automatic test_error_simul();
        bit ok;
        do_reset();
        set_mode(1'b0, 1'b1);
        push_tx(8'($urandom));
        push_tx(8'($urandom));
        wait_dreq("err_req", ok);
        DACK = 1'b1; tick();
        IOW_n = 1'b0; tick();
        IOW_n = 1'b1; tick();
        checks++;
        if (err_flag !== 1'b1) begin errors++; $display("FAIL err_set: err_flag=%b expected 1", err_flag); end
        IOR_n = 1'b0; tick(); tick();
        checks++;
        if (DB !== tx_q[0]) begin errors++; $display("FAIL err_db: DB=%h expected %h", DB, tx_q[0]); end
        IOR_n = 1'b1; tick();
        void'(tx_q.pop_front()); m_count++;
        DACK = 1'b0; tick();
        checks++;
        if (xfer_count !== 8'(m_count)) begin errors++; $display("FAIL err_count: xfer_count=%0d expected %0d", xfer_count, m_count); end
        dma_xfer("simul", 0, 1, 8'($urandom), 8'h00);
        dma_xfer("simul_next", 0, 0, 8'h00, 8'h00);
        quiet_dreq("simul_empty", 10);
        checks++;
        if (err_flag !== 1'b1) begin errors++; $display("FAIL err_sticky: err_flag=%b expected 1", err_flag); end
    endtask

    task automatic test_full();
        set_mode(1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) push_tx(8'($urandom));
        checks++;
        if (tx_full !== 1'b1) begin errors++; $display("FAIL tx_full: tx_full=%b expected 1", tx_full); end
        push_tx(8'($urandom));
        checks++;
        if (tx_full !== 1'b1) begin errors++; $display("FAIL tx_full_drop: tx_full=%b expected 1", tx_full); end
        enable = 1'b1;
        for (int i = 0; i < DEPTH; i++) dma_xfer("drain", 0, 0, 8'h00, 8'h00);
        quiet_dreq("drain_empty", 10);
    endtask

    task automatic test_wrap();
        do_reset();
        set_mode(1'b0, 1'b1);
        for (int i = 0; i < 256; i++) begin
            push_tx(8'($urandom));
            dma_xfer("wrap", 0, 0, 8'h00, 8'h00);
        end
        checks++;
        if (xfer_count !== 8'd0) begin errors++; $display("FAIL wrap_256: xfer_count=%0d expected 0", xfer_count); end
    endtask

    initial begin
        test_reset();
        test_source();
        test_sink();
        test_tc();
        test_abort();
        test_error_simul();
        test_full();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
